// File: rtl/sram_access_arbiter_pkg.sv
// sram_access_arbiter_pkg
// Shared definitions for the SRAM access arbiter: requester IDs, FSM state
// encodings, default memory geometry and a requester-ID decode helper.
package sram_access_arbiter_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_ADDR_WIDTH  = 9;
  localparam int DEFAULT_INSTR_WORDS = 256;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_LD  = 2'd0;
  localparam req_id_t REQ_CPU = 2'd1;
  localparam req_id_t REQ_ALU = 2'd2;

  // IDLE: SRAM idle, ISSUE: command on the SRAM pins, RDWAIT: read data cycle
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ISSUE  = 2'b01,
    ST_RDWAIT = 2'b10
  } arb_state_t;

  // Requester ID to one-hot strobe vector (bit index == requester ID)
  function automatic logic [2:0] req_onehot(input req_id_t id);
    logic [2:0] oh;
    case (id)
      REQ_LD:  oh = 3'b001;
      REQ_CPU: oh = 3'b010;
      REQ_ALU: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/sram_access_arbiter_if.sv
// sram_access_arbiter_if
// Bundles the three requester command/handshake channels, the SRAM macro pins
// and the status flags of the SRAM access arbiter.
//   slave  : arbiter side (consumes requests and Q_from_SRAM, drives SRAM pins)
//   master : requester/SRAM side (drives requests and Q_from_SRAM)
interface sram_access_arbiter_if
  import sram_access_arbiter_pkg::*;
#(
  parameter int MEMORY_DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MEMORY_ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic                         LOAD_N;
  logic                         LD_REQ,  CPU_REQ,  ALU_REQ;
  logic                         LD_WE,   CPU_WE,   ALU_WE;
  logic [MEMORY_ADDR_WIDTH-1:0] LD_A,    CPU_A,    ALU_A;
  logic [MEMORY_DATA_WIDTH-1:0] LD_D,    CPU_D,    ALU_D;
  logic                         LD_GNT,  CPU_GNT,  ALU_GNT;
  logic                         LD_RVLD, CPU_RVLD, ALU_RVLD;
  logic [MEMORY_DATA_WIDTH-1:0] RDATA;
  logic [MEMORY_DATA_WIDTH-1:0] Q_from_SRAM;
  logic                         CEN_after_mux;
  logic                         WEN_after_mux;
  logic [MEMORY_ADDR_WIDTH-1:0] A_after_mux;
  logic [MEMORY_DATA_WIDTH-1:0] D_after_mux;
  logic                         PROT_ERR;
  logic                         BUSY;

  modport slave (
    input  LOAD_N, LD_REQ, CPU_REQ, ALU_REQ, LD_WE, CPU_WE, ALU_WE,
           LD_A, CPU_A, ALU_A, LD_D, CPU_D, ALU_D, Q_from_SRAM,
    output LD_GNT, CPU_GNT, ALU_GNT, LD_RVLD, CPU_RVLD, ALU_RVLD, RDATA,
           CEN_after_mux, WEN_after_mux, A_after_mux, D_after_mux,
           PROT_ERR, BUSY
  );

  modport master (
    output LOAD_N, LD_REQ, CPU_REQ, ALU_REQ, LD_WE, CPU_WE, ALU_WE,
           LD_A, CPU_A, ALU_A, LD_D, CPU_D, ALU_D, Q_from_SRAM,
    input  LD_GNT, CPU_GNT, ALU_GNT, LD_RVLD, CPU_RVLD, ALU_RVLD, RDATA,
           CEN_after_mux, WEN_after_mux, A_after_mux, D_after_mux,
           PROT_ERR, BUSY
  );

endinterface

// File: rtl/sram_rr_arb2.sv
// sram_rr_arb2
// Two-input round-robin selector. A request whose mask bit is set is not
// eligible. On contention the pointer decides; after any grant the pointer
// favours the other input. Cycles with no grant leave the pointer alone.
//   clk, rst : clock, asynchronous active-high reset (pointer favours input 0)
//   req      : raw requests
//   mask     : per-input inhibit
//   gnt      : one-hot grant (combinational)
module sram_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic       ptr_r;
  logic [1:0] elig_s;

  // Eligibility and pointer-based tie break
  always_comb begin
    elig_s = req & ~mask;
    if (elig_s == 2'b11) begin
      gnt = ptr_r ? 2'b10 : 2'b01;
    end else begin
      gnt = elig_s;
    end
  end

  // Pointer moves to the loser of the most recent grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else if (gnt[0]) begin
      ptr_r <= 1'b1;
    end else if (gnt[1]) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter
// Shares one single-port SRAM between the program loader, the CPU and the
// ALU/analog controller. The winner's command is registered onto the SRAM
// pins together with a one-cycle GNT; read data returns one cycle later with
// a one-cycle RVLD to the owner.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : requester channels, SRAM pins and status flags
module sram_access_arbiter
  import sram_access_arbiter_pkg::*;
#(
  parameter int MEMORY_DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MEMORY_ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int INSTR_WORDS       = DEFAULT_INSTR_WORDS
) (
  input  logic                 CLK,
  input  logic                 RST,
  sram_access_arbiter_if.slave bus
);

  // One extra bit so INSTR_WORDS may equal the full address space
  localparam logic [MEMORY_ADDR_WIDTH:0] INSTR_LIMIT = (MEMORY_ADDR_WIDTH+1)'(INSTR_WORDS);

  arb_state_t                   state_r, state_nxt_s;
  logic [2:0]                   gnt_r, rvld_r, rvld_nxt_s, win_s;
  req_id_t                      id_r, sel_id_s;
  logic                         rd_r, rd_nxt_s;
  logic                         cen_r, cen_nxt_s, wen_r, wen_nxt_s;
  logic [MEMORY_ADDR_WIDTH-1:0] a_r, a_nxt_s, sel_a_s;
  logic [MEMORY_DATA_WIDTH-1:0] d_r, d_nxt_s, sel_d_s;
  logic                         prot_err_r, prot_nxt_s, busy_r;
  logic                         sel_we_s, blocked_s, issue_s, ld_win_s;
  logic [1:0]                   rr_req_s, rr_mask_s, rr_gnt_s;

  // CPU (bit 0) and ALU (bit 1) only compete in run mode
  assign rr_req_s  = {bus.ALU_REQ, bus.CPU_REQ} & {2{bus.LOAD_N}};
  assign rr_mask_s = {gnt_r[REQ_ALU], gnt_r[REQ_CPU]};

  sram_rr_arb2 u_rr (
    .clk  (CLK),
    .rst  (RST),
    .req  (rr_req_s),
    .mask (rr_mask_s),
    .gnt  (rr_gnt_s)
  );

  // Winner selection, command mux, protection check and FSM next state
  always_comb begin
    ld_win_s = ~bus.LOAD_N & bus.LD_REQ & ~gnt_r[REQ_LD];
    win_s    = {rr_gnt_s[1], rr_gnt_s[0], ld_win_s};

    if (win_s[REQ_LD]) begin
      sel_id_s = REQ_LD;  sel_we_s = bus.LD_WE;  sel_a_s = bus.LD_A;  sel_d_s = bus.LD_D;
    end else if (win_s[REQ_CPU]) begin
      sel_id_s = REQ_CPU; sel_we_s = bus.CPU_WE; sel_a_s = bus.CPU_A; sel_d_s = bus.CPU_D;
    end else if (win_s[REQ_ALU]) begin
      sel_id_s = REQ_ALU; sel_we_s = bus.ALU_WE; sel_a_s = bus.ALU_A; sel_d_s = bus.ALU_D;
    end else begin
      sel_id_s = id_r;    sel_we_s = 1'b0;       sel_a_s = a_r;       sel_d_s = d_r;
    end

    // A blocked ALU write is still granted but never reaches the SRAM pins
    blocked_s  = win_s[REQ_ALU] & bus.ALU_WE & ({1'b0, bus.ALU_A} < INSTR_LIMIT);
    issue_s    = (|win_s) & ~blocked_s;
    cen_nxt_s  = ~issue_s;
    wen_nxt_s  = ~(issue_s & sel_we_s);
    a_nxt_s    = issue_s ? sel_a_s : a_r;
    d_nxt_s    = issue_s ? sel_d_s : d_r;
    rd_nxt_s   = issue_s & ~sel_we_s;
    prot_nxt_s = prot_err_r | blocked_s;

    // The SRAM samples at the end of ISSUE, so data is valid in the cycle after
    if ((state_r == ST_ISSUE) && rd_r) begin
      rvld_nxt_s = req_onehot(id_r);
    end else begin
      rvld_nxt_s = 3'b000;
    end

    case (state_r)
      ST_ISSUE: begin
        if (issue_s) begin
          state_nxt_s = ST_ISSUE;
        end else if (rd_r) begin
          state_nxt_s = ST_RDWAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_IDLE, ST_RDWAIT: begin
        state_nxt_s = issue_s ? ST_ISSUE : ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State and registered output stage
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      gnt_r      <= 3'b000;
      rvld_r     <= 3'b000;
      id_r       <= REQ_LD;
      rd_r       <= 1'b0;
      cen_r      <= 1'b1;
      wen_r      <= 1'b1;
      a_r        <= {MEMORY_ADDR_WIDTH{1'b0}};
      d_r        <= {MEMORY_DATA_WIDTH{1'b0}};
      prot_err_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      gnt_r      <= win_s;
      rvld_r     <= rvld_nxt_s;
      id_r       <= sel_id_s;
      rd_r       <= rd_nxt_s;
      cen_r      <= cen_nxt_s;
      wen_r      <= wen_nxt_s;
      a_r        <= a_nxt_s;
      d_r        <= d_nxt_s;
      prot_err_r <= prot_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.LD_GNT        = gnt_r[REQ_LD];
  assign bus.CPU_GNT       = gnt_r[REQ_CPU];
  assign bus.ALU_GNT       = gnt_r[REQ_ALU];
  assign bus.LD_RVLD       = rvld_r[REQ_LD];
  assign bus.CPU_RVLD      = rvld_r[REQ_CPU];
  assign bus.ALU_RVLD      = rvld_r[REQ_ALU];
  assign bus.RDATA         = bus.Q_from_SRAM;
  assign bus.CEN_after_mux = cen_r;
  assign bus.WEN_after_mux = wen_r;
  assign bus.A_after_mux   = a_r;
  assign bus.D_after_mux   = d_r;
  assign bus.PROT_ERR      = prot_err_r;
  assign bus.BUSY          = busy_r;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter
// Directed bench for sram_access_arbiter with a behavioural SRAM and
// per-requester queues of expected read data.
module tb_sram_access_arbiter;

  localparam int ID_LD  = 0;
  localparam int ID_CPU = 1;
  localparam int ID_ALU = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         errors = 0;
  int         last_lat = 0;
  logic [7:0] mem     [512];
  logic [7:0] ref_mem [512];
  logic [7:0] q_r = 8'h00;
  logic [7:0] cpu_q[$];
  logic [7:0] alu_q[$];

  sram_access_arbiter_if #(.MEMORY_DATA_WIDTH(8), .MEMORY_ADDR_WIDTH(9)) bus ();

  sram_access_arbiter #(
    .MEMORY_DATA_WIDTH(8), .MEMORY_ADDR_WIDTH(9), .INSTR_WORDS(256)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM
  always @(posedge clk) begin
    if (!bus.CEN_after_mux) begin
      if (!bus.WEN_after_mux) mem[bus.A_after_mux] <= bus.D_after_mux;
      else q_r <= mem[bus.A_after_mux];
    end
  end
  assign bus.Q_from_SRAM = q_r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic gnt_of(input int id);
    case (id)
      ID_LD:   return bus.LD_GNT;
      ID_CPU:  return bus.CPU_GNT;
      default: return bus.ALU_GNT;
    endcase
  endfunction

  task automatic set_cmd(input int id, input logic req, input logic we,
                         input logic [8:0] a, input logic [7:0] d);
    case (id)
      ID_LD:   begin bus.LD_REQ  = req; bus.LD_WE  = we; bus.LD_A  = a; bus.LD_D  = d; end
      ID_CPU:  begin bus.CPU_REQ = req; bus.CPU_WE = we; bus.CPU_A = a; bus.CPU_D = d; end
      default: begin bus.ALU_REQ = req; bus.ALU_WE = we; bus.ALU_A = a; bus.ALU_D = d; end
    endcase
  endtask

  task automatic push_exp(input int id, input logic [7:0] v);
    if (id == ID_CPU) cpu_q.push_back(v);
    else alu_q.push_back(v);
  endtask

  // Bounded wait (sampled on negedges) for a requester's grant
  task automatic wait_gnt(input int id);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt_of(id) && n < 20);
    last_lat = n;
    check($sformatf("gnt_seen_%0d", id), 32'(gnt_of(id)), 32'd1);
  endtask

  // One access: drive, wait for grant, release; returns at the grant cycle
  task automatic access(input int id, input logic we, input logic [8:0] a,
                        input logic [7:0] d, input bit exp_rvld);
    @(negedge clk);
    set_cmd(id, 1'b1, we, a, d);
    if (!we && exp_rvld) push_exp(id, ref_mem[a]);
    wait_gnt(id);
    set_cmd(id, 1'b0, we, a, d);
  endtask

  // Read-data monitor: every RVLD must match the owner's oldest expectation
  always @(negedge clk) begin
    if (bus.LD_RVLD) check("ld_rvld_unexp", 32'(bus.LD_RVLD), 32'd0);
    if (bus.CPU_RVLD) begin
      if (cpu_q.size() == 0) check("cpu_rvld_unexp", 32'(bus.CPU_RVLD), 32'd0);
      else check("cpu_rdata", 32'(bus.RDATA), 32'(cpu_q.pop_front()));
    end
    if (bus.ALU_RVLD) begin
      if (alu_q.size() == 0) check("alu_rvld_unexp", 32'(bus.ALU_RVLD), 32'd0);
      else check("alu_rdata", 32'(bus.RDATA), 32'(alu_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] wa [4];
    logic [7:0] wd [4];
    bit         wblk [4];
    int         cpu_k, alu_k;
    bit         exp_cpu;

    wa = '{9'h050, 9'h0FF, 9'h100, 9'h150};
    wd = '{8'hFF, 8'h11, 8'h22, 8'h77};
    wblk = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 512; i++) begin
      mem[i]     = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    mem[9'h010] = 8'hA5;
    ref_mem[9'h010] = 8'hA5;
    bus.LOAD_N = 1'b1;
    set_cmd(ID_LD,  1'b0, 1'b0, 9'h000, 8'h00);
    set_cmd(ID_CPU, 1'b0, 1'b0, 9'h000, 8'h00);
    set_cmd(ID_ALU, 1'b0, 1'b0, 9'h000, 8'h00);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_cen", 32'(bus.CEN_after_mux), 32'd1);
    check("rst_wen", 32'(bus.WEN_after_mux), 32'd1);
    check("rst_a", 32'(bus.A_after_mux), 32'd0);
    check("rst_d", 32'(bus.D_after_mux), 32'd0);
    check("rst_gnt", 32'({bus.LD_GNT, bus.CPU_GNT, bus.ALU_GNT}), 32'd0);
    check("rst_rvld", 32'({bus.LD_RVLD, bus.CPU_RVLD, bus.ALU_RVLD}), 32'd0);
    check("rst_prot", 32'(bus.PROT_ERR), 32'd0);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    rst = 1'b0;

    // CPU read of preloaded 0x010
    access(ID_CPU, 1'b0, 9'h010, 8'h00, 1'b1);
    check("rd_latency", 32'(last_lat), 32'd1);
    check("rd_cen", 32'(bus.CEN_after_mux), 32'd0);
    check("rd_wen", 32'(bus.WEN_after_mux), 32'd1);
    check("rd_a", 32'(bus.A_after_mux), 32'h010);
    check("rd_busy_issue", 32'(bus.BUSY), 32'd1);
    @(negedge clk);
    check("rd_rvld", 32'(bus.CPU_RVLD), 32'd1);
    check("rd_gnt_pulse", 32'(bus.CPU_GNT), 32'd0);
    check("rd_cen_idle", 32'(bus.CEN_after_mux), 32'd1);
    check("rd_busy_wait", 32'(bus.BUSY), 32'd1);
    @(negedge clk);
    check("rd_busy_done", 32'(bus.BUSY), 32'd0);

    // Loader-exclusive mode with CPU_REQ held
    bus.LOAD_N = 1'b0;
    set_cmd(ID_CPU, 1'b1, 1'b0, 9'h000, 8'h00);
    set_cmd(ID_LD, 1'b1, 1'b1, 9'h000, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ld_gnt", 32'(bus.LD_GNT), 32'd1);
      check("ld_cpu_gnt", 32'(bus.CPU_GNT), 32'd0);
      check("ld_wen", 32'(bus.WEN_after_mux), 32'd0);
      check("ld_a", 32'(bus.A_after_mux), 32'(i));
      check("ld_d", 32'(bus.D_after_mux), 32'h3C);
      ref_mem[i] = 8'h3C;
      if (i < 3) bus.LD_A = 9'(i + 1);
      else bus.LD_REQ = 1'b0;
      @(negedge clk);
      check("ld_gnt_gap", 32'(bus.LD_GNT), 32'd0);
      check("ld_cpu_gnt_gap", 32'(bus.CPU_GNT), 32'd0);
      check("ld_cen_gap", 32'(bus.CEN_after_mux), 32'd1);
    end
    bus.LOAD_N = 1'b1;
    push_exp(ID_CPU, ref_mem[0]);
    wait_gnt(ID_CPU);
    check("run_cpu_a", 32'(bus.A_after_mux), 32'd0);
    bus.CPU_REQ = 1'b0;

    // Single ALU read leaves the pointer favouring CPU
    access(ID_ALU, 1'b0, 9'h020, 8'h00, 1'b1);

    // CPU and ALU held continuously: alternate grants every cycle
    @(negedge clk);
    cpu_k = 0;
    alu_k = 0;
    set_cmd(ID_CPU, 1'b1, 1'b0, 9'h100, 8'h00);
    set_cmd(ID_ALU, 1'b1, 1'b0, 9'h180, 8'h00);
    push_exp(ID_CPU, ref_mem[9'h100]);
    push_exp(ID_ALU, ref_mem[9'h180]);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_cpu = (k % 2 == 0);
      check("alt_cpu_gnt", 32'(bus.CPU_GNT), 32'(exp_cpu));
      check("alt_alu_gnt", 32'(bus.ALU_GNT), 32'(!exp_cpu));
      check("alt_cen", 32'(bus.CEN_after_mux), 32'd0);
      check("alt_a", 32'(bus.A_after_mux), exp_cpu ? 32'(9'h100 + 9'(cpu_k)) : 32'(9'h180 + 9'(alu_k)));
      if (exp_cpu) begin
        cpu_k++;
        if (cpu_k < 3) begin
          bus.CPU_A = 9'h100 + 9'(cpu_k);
          push_exp(ID_CPU, ref_mem[bus.CPU_A]);
        end else bus.CPU_REQ = 1'b0;
      end else begin
        alu_k++;
        if (alu_k < 3) begin
          bus.ALU_A = 9'h180 + 9'(alu_k);
          push_exp(ID_ALU, ref_mem[bus.ALU_A]);
        end else bus.ALU_REQ = 1'b0;
      end
    end

    // ALU writes around the instruction-region boundary
    for (int i = 0; i < 4; i++) begin
      access(ID_ALU, 1'b1, wa[i], wd[i], 1'b0);
      check("prot_cen", 32'(bus.CEN_after_mux), 32'(wblk[i]));
      check("prot_wen", 32'(bus.WEN_after_mux), 32'(wblk[i]));
      check("prot_flag", 32'(bus.PROT_ERR), 32'd1);
      if (!wblk[i]) begin
        check("alu_wr_a", 32'(bus.A_after_mux), 32'(wa[i]));
        check("alu_wr_d", 32'(bus.D_after_mux), 32'(wd[i]));
        ref_mem[wa[i]] = wd[i];
      end
    end
    for (int i = 0; i < 4; i++) access(ID_CPU, 1'b0, wa[i], 8'h00, 1'b1);
    @(negedge clk);
    check("prot_sticky", 32'(bus.PROT_ERR), 32'd1);

    // Reset in the cycle after a CPU read grant aborts the read
    access(ID_CPU, 1'b0, 9'h010, 8'h00, 1'b0);
    rst = 1'b1;
    #1;
    check("abort_cen", 32'(bus.CEN_after_mux), 32'd1);
    check("abort_wen", 32'(bus.WEN_after_mux), 32'd1);
    check("abort_a", 32'(bus.A_after_mux), 32'd0);
    check("abort_gnt", 32'(bus.CPU_GNT), 32'd0);
    check("abort_busy", 32'(bus.BUSY), 32'd0);
    check("abort_prot", 32'(bus.PROT_ERR), 32'd0);
    @(negedge clk);
    check("abort_no_rvld", 32'(bus.CPU_RVLD), 32'd0);
    rst = 1'b0;

    // Simultaneous CPU and ALU after reset: CPU first
    @(negedge clk);
    set_cmd(ID_CPU, 1'b1, 1'b0, 9'h010, 8'h00);
    set_cmd(ID_ALU, 1'b1, 1'b0, 9'h181, 8'h00);
    push_exp(ID_CPU, ref_mem[9'h010]);
    push_exp(ID_ALU, ref_mem[9'h181]);
    @(negedge clk);
    check("post_rst_cpu_first", 32'(bus.CPU_GNT), 32'd1);
    check("post_rst_alu_wait", 32'(bus.ALU_GNT), 32'd0);
    bus.CPU_REQ = 1'b0;
    @(negedge clk);
    check("post_rst_alu_next", 32'(bus.ALU_GNT), 32'd1);
    bus.ALU_REQ = 1'b0;
    repeat (3) @(negedge clk);

    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check("alu_q_drained", 32'(alu_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
